// File: rtl/multi_array_pkg.sv
// multi_array_pkg
// Shared definitions for the stream-to-array loader:
//   IDX_W(n)        index width needed to address n entries (at least 1 bit)
//   loader_state_t  LOAD while words are being accepted, FULL once the array is complete
//   OW_DEFAULT      default stored word / running sum width
package multi_array_pkg;

  localparam int OW_DEFAULT = 32;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } loader_state_t;

  function automatic int IDX_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/array_index_walker.sv
// array_index_walker
// Nested three-level wrap counter producing the row-major (i, j, k) write
// position, k innermost.
// Ports:
//   clk   clock, all state on the rising edge
//   rst   synchronous active-high reset, indices -> (0,0,0)
//   clr   synchronous restart, same effect as rst
//   step  advance to the next position
//   i/j/k current position
//   last  combinational, high while the position is (D0-1, D1-1, D2-1)
module array_index_walker
  import multi_array_pkg::*;
#(
  parameter int D0 = 2,
  parameter int D1 = 3,
  parameter int D2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  step,
  output logic [IDX_W(D0)-1:0]  i,
  output logic [IDX_W(D1)-1:0]  j,
  output logic [IDX_W(D2)-1:0]  k,
  output logic                  last
);

  localparam int W0 = IDX_W(D0);
  localparam int W1 = IDX_W(D1);
  localparam int W2 = IDX_W(D2);
  localparam logic [W0-1:0] I_MAX = W0'(D0 - 1);
  localparam logic [W1-1:0] J_MAX = W1'(D1 - 1);
  localparam logic [W2-1:0] K_MAX = W2'(D2 - 1);

  logic [W0-1:0] i_q, i_d;
  logic [W1-1:0] j_q, j_d;
  logic [W2-1:0] k_q, k_d;
  logic          k_wrap, j_wrap, i_wrap;

  assign k_wrap = (k_q == K_MAX);
  assign j_wrap = (j_q == J_MAX);
  assign i_wrap = (i_q == I_MAX);
  assign last   = i_wrap && j_wrap && k_wrap;

  // Carry ripples outward: k wraps first, then j, then i.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (step) begin
      if (k_wrap) begin
        k_d = '0;
        if (j_wrap) begin
          j_d = '0;
          i_d = i_wrap ? '0 : i_q + W0'(1);
        end else begin
          j_d = j_q + W1'(1);
        end
      end else begin
        k_d = k_q + W2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i = i_q;
  assign j = j_q;
  assign k = k_q;

endmodule

// File: rtl/multi_array_loader.sv
// multi_array_loader
// Accepts a valid/ready stream of IW-bit elements and writes them, extended
// to OW bits, into a D0 x D1 x D2 register array in row-major order (k
// innermost), keeping a running OW-bit sum of the stored words.
// Optional feature macro: MULTI_ARRAY_LOADER_SEXT_EN
//   defined   -> elements are sign-extended to OW bits
//   undefined -> elements are zero-extended
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   stream handshake, in_data is the element
//   clear               restart pulse: empties the array and the sum
//   done                array completely loaded
//   sum                 running sum of stored words (wraps modulo 2^OW)
//   cur_i/cur_j/cur_k   position of the next write
//   rd_i/rd_j/rd_k      readback address, rd_data is the word there
//                       (0 when any index is out of range or during reset)
module multi_array_loader
  import multi_array_pkg::*;
#(
  parameter int D0 = 2,
  parameter int D1 = 3,
  parameter int D2 = 4,
  parameter int IW = 16,
  parameter int OW = OW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IW-1:0]         in_data,
  input  logic                  clear,
  output logic                  done,
  output logic [OW-1:0]         sum,
  output logic [IDX_W(D0)-1:0]  cur_i,
  output logic [IDX_W(D1)-1:0]  cur_j,
  output logic [IDX_W(D2)-1:0]  cur_k,
  input  logic [IDX_W(D0)-1:0]  rd_i,
  input  logic [IDX_W(D1)-1:0]  rd_j,
  input  logic [IDX_W(D2)-1:0]  rd_k,
  output logic [OW-1:0]         rd_data
);

  localparam int W0    = IDX_W(D0);
  localparam int W1    = IDX_W(D1);
  localparam int W2    = IDX_W(D2);
  localparam int DEPTH = D0 * D1 * D2;
  localparam int AW    = IDX_W(DEPTH);

  loader_state_t  state_q;
  logic [OW-1:0]  sum_q;
  logic [OW-1:0]  mem_q [DEPTH];

  logic [W0-1:0]  wi;
  logic [W1-1:0]  wj;
  logic [W2-1:0]  wk;
  logic           w_last;
  logic           accept;
  logic [OW-1:0]  ext_data;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;
  logic           rd_in_range;

`ifdef MULTI_ARRAY_LOADER_SEXT_EN
  assign ext_data = OW'($signed(in_data));
`else
  assign ext_data = OW'(in_data);
`endif

  // clear takes priority over a simultaneous beat by dropping ready.
  assign in_ready = (state_q == LOAD) && !rst && !clear;
  assign accept   = in_valid && in_ready;

  array_index_walker #(
    .D0(D0),
    .D1(D1),
    .D2(D2)
  ) u_walker (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .step (accept),
    .i    (wi),
    .j    (wj),
    .k    (wk),
    .last (w_last)
  );

  always_comb begin
    int a;
    a       = (int'(wi) * D1 + int'(wj)) * D2 + int'(wk);
    wr_addr = AW'(a);
  end

  always_comb begin
    int a;
    a           = (int'(rd_i) * D1 + int'(rd_j)) * D2 + int'(rd_k);
    rd_addr     = AW'(a);
    rd_in_range = (int'(rd_i) < D0) && (int'(rd_j) < D1) && (int'(rd_k) < D2);
  end

  // Control FSM: the last accepted beat moves LOAD -> FULL; only
  // clear or reset brings it back.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= LOAD;
      sum_q   <= '0;
    end else if (accept) begin
      sum_q <= sum_q + ext_data;
      if (w_last) begin
        state_q <= FULL;
      end
    end
  end

  // Storage is a plain register array: restart must zero every word in
  // one cycle and readback is combinational.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int n = 0; n < DEPTH; n++) begin
        mem_q[n] <= '0;
      end
    end else if (accept) begin
      mem_q[wr_addr] <= ext_data;
    end
  end

  // Outputs are forced to their restart values while reset is held, so
  // they read clean even before the first reset edge.
  assign done    = (state_q == FULL) && !rst;
  assign sum     = rst ? '0 : sum_q;
  assign cur_i   = rst ? '0 : wi;
  assign cur_j   = rst ? '0 : wj;
  assign cur_k   = rst ? '0 : wk;
  assign rd_data = (rst || !rd_in_range) ? '0 : mem_q[rd_addr];

endmodule

// File: tb/tb_multi_array_loader.sv
module tb_multi_array_loader;
  import multi_array_pkg::*;

  localparam int D0 = 2;
  localparam int D1 = 3;
  localparam int D2 = 4;
  localparam int IW = 16;
  localparam int OW = 32;
  localparam int N  = D0 * D1 * D2;
  localparam int W0 = IDX_W(D0);
  localparam int W1 = IDX_W(D1);
  localparam int W2 = IDX_W(D2);

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  in_data;
  logic           clear;
  logic           done;
  logic [OW-1:0]  sum;
  logic [W0-1:0]  cur_i, rd_i;
  logic [W1-1:0]  cur_j, rd_j;
  logic [W2-1:0]  cur_k, rd_k;
  logic [OW-1:0]  rd_data;

  multi_array_loader #(
    .D0(D0), .D1(D1), .D2(D2), .IW(IW), .OW(OW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .clear    (clear),
    .done     (done),
    .sum      (sum),
    .cur_i    (cur_i),
    .cur_j    (cur_j),
    .cur_k    (cur_k),
    .rd_i     (rd_i),
    .rd_j     (rd_j),
    .rd_k     (rd_k),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] data;
    logic [OW-1:0] exp_sum;
    logic          exp_done;
  } vec_t;

  typedef struct {
    int            i;
    int            j;
    int            k;
    logic [OW-1:0] word;
  } sb_t;

  vec_t          tbl [N];
  sb_t           sbq [$];
  int            n_vec  = 0;
  int            n_miss = 0;

  // Reference model state
  int            m_beats;
  logic          m_full;
  logic [OW-1:0] m_sum;
  logic [OW-1:0] m_mem [N];

  function automatic logic [OW-1:0] ext(input logic [IW-1:0] x);
`ifdef MULTI_ARRAY_LOADER_SEXT_EN
    return {{(OW-IW){x[IW-1]}}, x};
`else
    return {{(OW-IW){1'b0}}, x};
`endif
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_restart();
    m_beats = 0;
    m_full  = 1'b0;
    m_sum   = '0;
    for (int n = 0; n < N; n++) m_mem[n] = '0;
  endtask

  task automatic rd_check(input string nm, input int i, input int j, input int k,
                          input logic [OW-1:0] exp);
    rd_i = W0'(i);
    rd_j = W1'(j);
    rd_k = W2'(k);
    #1;
    check(nm, rd_data, exp);
  endtask

  task automatic check_cur(input string nm);
    check({nm, "_ci"}, cur_i, m_beats / (D1 * D2));
    check({nm, "_cj"}, cur_j, (m_beats / D2) % D1);
    check({nm, "_ck"}, cur_k, m_beats % D2);
  endtask

  // One clock cycle: drive, check ready, clock, then score the result.
  task automatic apply(input logic v, input logic [IW-1:0] d, input logic clr);
    logic acc;
    sb_t  e;
    in_valid = v;
    in_data  = d;
    clear    = clr;
    #1;
    check("ready", in_ready, !m_full && !clr);
    acc = v && !m_full && !clr;
    if (acc) begin
      e.i    = m_beats / (D1 * D2);
      e.j    = (m_beats / D2) % D1;
      e.k    = m_beats % D2;
      e.word = ext(d);
      sbq.push_back(e);
      m_mem[m_beats] = ext(d);
      m_sum   = m_sum + ext(d);
      m_beats = m_beats + 1;
      if (m_beats == N) begin
        m_beats = 0;
        m_full  = 1'b1;
      end
    end
    if (clr) model_restart();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    in_data  = $urandom_range(0, 16'hFFFF);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      rd_check("rd_written", e.i, e.j, e.k, e.word);
    end
    check("sum", sum, m_sum);
    check("done", done, m_full);
    check_cur("cur");
  endtask

  task automatic check_all_words(input string nm);
    for (int n = 0; n < N; n++)
      rd_check(nm, n / (D1 * D2), (n / D2) % D1, n % D2, m_mem[n]);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clear    = 1'b0;
    rd_i     = '0;
    rd_j     = '0;
    rd_k     = '0;
    model_restart();

    for (int n = 0; n < N; n++) begin
      tbl[n].data     = IW'(n + 1);
      tbl[n].exp_sum  = OW'((n + 1) * (n + 2) / 2);
      tbl[n].exp_done = (n == N - 1);
    end

    // Reset state
    #1;
    check("rst_ready", in_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1'b1);
    check_cur("post_rst");

    // Full load, back-to-back
    for (int n = 0; n < N; n++) begin
      apply(1'b1, tbl[n].data, 1'b0);
      check("tbl_sum", sum, tbl[n].exp_sum);
      check("tbl_done", done, tbl[n].exp_done);
    end
    rd_check("a000", 0, 0, 0, 32'd1);
    rd_check("a023", 0, 2, 3, 32'd12);
    rd_check("a123", 1, 2, 3, 32'd24);
    check("full_sum", sum, 32'd300);
    apply(1'b1, 16'd99, 1'b0);           // beat offered while FULL is refused
    check("full_hold_sum", sum, 32'd300);
    rd_check("oor_j", 1, 3, 3, 32'd0);
    rd_check("oor_j0", 0, 3, 0, 32'd0);

    // Restart and load with a gap every other cycle: 48 cycles
    apply(1'b0, 16'd0, 1'b1);
    rd_check("cleared", 1, 2, 3, 32'd0);
    for (int n = 0; n < 2 * N; n++) begin
      apply(n % 2 == 1, IW'((n + 1) / 2), 1'b0);
      check("gap_done", done, n == 2 * N - 1);
    end
    check("gap_sum", sum, 32'd300);
    check_all_words("gap_word");

    // Reset while FULL
    rst = 1'b1;
    #1;
    check("rstfull_ready", in_ready, 1'b0);
    check("rstfull_done_in", done, 1'b0);
    check("rstfull_sum_in", sum, 0);
    rd_check("rstfull_rd_in", 1, 2, 3, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_restart();
    check("rstfull_done", done, 1'b0);
    check("rstfull_sum", sum, 0);
    rd_check("rstfull_rd", 1, 2, 3, 32'd0);

    // clear mid-load wins over a simultaneous beat
    for (int n = 0; n < 10; n++) apply(1'b1, IW'(n + 1), 1'b0);
    check("mid_sum", sum, 32'd55);
    apply(1'b1, 16'd77, 1'b1);
    check("clr_sum", sum, 0);
    check("clr_ci", cur_i, 0);
    check("clr_cj", cur_j, 0);
    check("clr_ck", cur_k, 0);
    rd_check("clr_word", 0, 0, 0, 32'd0);
    for (int n = 0; n < N; n++) apply(1'b1, 16'd2, 1'b0);
    check("reload_sum", sum, 32'd48);
    check("reload_done", done, 1'b1);

    // Extension of a negative-looking element
    apply(1'b0, 16'd0, 1'b1);
    for (int n = 0; n < N; n++) apply(1'b1, 16'h8000, 1'b0);
`ifdef MULTI_ARRAY_LOADER_SEXT_EN
    check("ext_sum", sum, 32'hFFF4_0000);
    rd_check("ext_word", 1, 1, 1, 32'hFFFF_8000);
`else
    check("ext_sum", sum, 32'h000C_0000);
    rd_check("ext_word", 1, 1, 1, 32'h0000_8000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
